// File: rtl/amo_unit.sv
// Atomic memory operation responder: runs LR/SC/AMO read-modify-write sequences
// on the dcache port while the pipeline is frozen, and holds the hart's LR/SC reservation.
//
// state | meaning
// IDLE  | waiting for amo_req; latches and decodes the operation
// RD    | dcache load outstanding (dc_req high until dc_ack)
// WR    | first cycle registers the decision; then store outstanding unless skipped
// ACK   | one-cycle amo_ack with rd result and error flag
module amo_unit #(
    parameter int XLEN          = 64,
    parameter int RSV_GRAN_LOG2 = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_amo_req,
    input  logic [4:0]      i_amo_funct5,
    input  logic [2:0]      i_amo_funct3,
    input  logic [XLEN-1:0] i_amo_addr,
    input  logic [XLEN-1:0] i_amo_wdata,
    output logic            o_amo_ack,
    output logic            o_amo_err,
    output logic [XLEN-1:0] o_amo_rdata,
    input  logic            i_rsv_inv,
    output logic            o_dc_req,
    output logic            o_dc_we,
    output logic [1:0]      o_dc_size,
    output logic [XLEN-1:0] o_dc_addr,
    output logic [XLEN-1:0] o_dc_wdata,
    input  logic [XLEN-1:0] i_dc_rdata,
    input  logic            i_dc_ack
);

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ACK} state_t;

    state_t                      r_state, w_next;
    logic [4:0]                  r_funct5;
    logic                        r_is_w, r_err, r_skip, r_wr_issued;
    logic [XLEN-1:0]             r_addr, r_wdata, r_new, r_rdata;
    logic                        r_rsv_valid;
    logic [XLEN-RSV_GRAN_LOG2-1:0] r_rsv_addr;

    logic            w_is_w, w_is_d, w_f5_ok, w_misal, w_illegal;
    logic            w_is_sc, w_gran_hit, w_sc_fail, w_skip, w_req_new;
    logic [XLEN-1:0] w_old, w_src, w_res;

    always_comb begin
        w_is_w  = (i_amo_funct3 == 3'b010);
        w_is_d  = (i_amo_funct3 == 3'b011);
        w_f5_ok = 1'b0;
        case (i_amo_funct5)
            F5_ADD, F5_SWAP, F5_LR, F5_SC, F5_XOR, F5_OR, F5_AND,
            F5_MIN, F5_MAX, F5_MINU, F5_MAXU: w_f5_ok = 1'b1;
            default:                          w_f5_ok = 1'b0;
        endcase
        w_misal    = w_is_w ? (|i_amo_addr[1:0]) : (|i_amo_addr[2:0]);
        w_illegal  = !(w_is_w || w_is_d) || !w_f5_ok || w_misal;
        w_is_sc    = (i_amo_funct5 == F5_SC);
        w_gran_hit = r_rsv_valid && (i_amo_addr[XLEN-1:RSV_GRAN_LOG2] == r_rsv_addr);
        w_sc_fail  = w_is_sc && !w_gran_hit;
        w_skip     = w_illegal || w_sc_fail;
        w_req_new  = (r_state == S_IDLE) && i_amo_req;
    end

    // W operands are sign-extended so one 64-bit comparator serves signed and unsigned ops.
    always_comb begin
        w_old = r_is_w ? {{(XLEN-32){i_dc_rdata[31]}}, i_dc_rdata[31:0]} : i_dc_rdata;
        w_src = r_is_w ? {{(XLEN-32){r_wdata[31]}}, r_wdata[31:0]} : r_wdata;
        w_res = w_src;
        case (r_funct5)
            F5_ADD:  w_res = w_old + w_src;
            F5_XOR:  w_res = w_old ^ w_src;
            F5_AND:  w_res = w_old & w_src;
            F5_OR:   w_res = w_old | w_src;
            F5_MIN:  w_res = ($signed(w_old) < $signed(w_src)) ? w_old : w_src;
            F5_MAX:  w_res = ($signed(w_old) > $signed(w_src)) ? w_old : w_src;
            F5_MINU: w_res = (w_old < w_src) ? w_old : w_src;
            F5_MAXU: w_res = (w_old > w_src) ? w_old : w_src;
            default: w_res = w_src;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_amo_req) w_next = (w_skip || w_is_sc) ? S_WR : S_RD;
            S_RD:   if (i_dc_ack)  w_next = (r_funct5 == F5_LR) ? S_ACK : S_WR;
            S_WR:   if (r_skip || (r_wr_issued && i_dc_ack)) w_next = S_ACK;
            S_ACK:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_amo_ack   = (r_state == S_ACK);
        o_amo_err   = (r_state == S_ACK) && r_err;
        o_amo_rdata = (r_state == S_ACK) ? r_rdata : '0;
        o_dc_req    = (r_state == S_RD) || ((r_state == S_WR) && r_wr_issued);
        o_dc_we     = (r_state == S_WR);
        o_dc_size   = r_is_w ? 2'd2 : 2'd3;
        o_dc_addr   = r_addr;
        o_dc_wdata  = r_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct5    <= '0;
            r_is_w      <= 1'b0;
            r_err       <= 1'b0;
            r_skip      <= 1'b0;
            r_wr_issued <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_new       <= '0;
            r_rdata     <= '0;
        end else begin
            r_wr_issued <= (r_state == S_WR) && !r_skip && !(r_wr_issued && i_dc_ack);
            if (w_req_new) begin
                r_funct5 <= i_amo_funct5;
                r_is_w   <= w_is_w;
                r_err    <= w_illegal;
                r_skip   <= w_skip;
                r_addr   <= i_amo_addr;
                r_wdata  <= i_amo_wdata;
                r_rdata  <= {{(XLEN-1){1'b0}}, w_sc_fail && !w_illegal};
                r_new    <= w_is_w ? {{(XLEN-32){1'b0}}, i_amo_wdata[31:0]} : i_amo_wdata;
            end else if ((r_state == S_RD) && i_dc_ack) begin
                r_rdata  <= w_old;
                r_new    <= r_is_w ? {{(XLEN-32){1'b0}}, w_res[31:0]} : w_res;
            end
        end
    end

    // Invalidation has priority over the LR set in its ACK cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsv_valid <= 1'b0;
            r_rsv_addr  <= '0;
        end else begin
            if ((r_state == S_ACK) && (r_funct5 == F5_LR) && !r_err)
                r_rsv_addr <= r_addr[XLEN-1:RSV_GRAN_LOG2];
            if (i_rsv_inv)
                r_rsv_valid <= 1'b0;
            else if (w_req_new && w_is_sc)
                r_rsv_valid <= 1'b0;
            else if ((r_state == S_ACK) && (r_funct5 == F5_LR) && !r_err)
                r_rsv_valid <= 1'b1;
            else if ((r_state == S_WR) && r_wr_issued && i_dc_ack && (r_funct5 != F5_SC) &&
                     (r_addr[XLEN-1:RSV_GRAN_LOG2] == r_rsv_addr))
                r_rsv_valid <= 1'b0;
        end
    end

    a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
                                 (r_state != S_IDLE) |-> i_amo_req);

endmodule
